// File: rtl/shift_pkg.sv
// shift_pkg: shared types and constants for the shift command sequencer
package shift_pkg;
  localparam int SHIFT_MAX_N = 8;
  typedef struct packed {
    logic [7:0] data;
    logic [3:0] n;
    logic       ar;
    logic       lr;
    logic       rot;
    logic       chain;
  } shift_cmd_t;
  typedef enum logic [1:0] {IDLE, ISSUE, STALL} seq_state_t;
endpackage

// File: rtl/shift_cmd_sequencer_cmd_fifo.sv
// cmd_fifo: synchronous FIFO of shift commands
// Ports: clk, rst_n (async active-low), i_push/i_data write side,
//        i_pop read side, o_head oldest entry, o_full/o_empty/o_count status.
module cmd_fifo
  import shift_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  shift_cmd_t    i_data,
  input  logic          i_pop,
  output shift_cmd_t    o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  shift_cmd_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop) r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
endmodule

// File: rtl/shift_cmd_sequencer.sv
// shift_cmd_sequencer: queues shift commands, drives an external shift unit, registers results
// Ports: in_* command input (valid/ready), sh_* / sh_o shift unit interface,
//        out_* registered result (valid/ready), busy, count (FIFO occupancy).
// Optional SHIFT_CMD_SEQUENCER_STATS_EN adds done_cnt, a 16-bit count of output handshakes.
module shift_cmd_sequencer
  import shift_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = 8,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [3:0]    in_n,
  input  logic          in_ar,
  input  logic          in_lr,
  input  logic          in_rot,
  input  logic          in_chain,
  output logic [W-1:0]  sh_i,
  output logic [3:0]    sh_n,
  output logic          sh_ar,
  output logic          sh_lr,
  output logic          sh_rot,
  input  logic [W-1:0]  sh_o,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          busy,
`ifdef SHIFT_CMD_SEQUENCER_STATS_EN
  output logic [15:0]   done_cnt,
`endif
  output logic [CW-1:0] count
);
  shift_cmd_t w_cmd, w_head;
  logic       w_push, w_pop, w_full, w_empty, w_last, w_stall;
  logic [3:0] w_n;
  logic       r_out_valid;
  logic [W-1:0] r_out_data, r_acc;
  seq_state_t r_state;
  assign w_n    = (in_n > 4'(SHIFT_MAX_N)) ? 4'(SHIFT_MAX_N) : in_n;
  assign w_cmd  = '{data: in_data, n: w_n, ar: in_ar, lr: in_lr, rot: in_rot, chain: in_chain};
  assign in_ready = !w_full;
  assign w_push = in_valid && in_ready;
  // Issue whenever a command waits and the output slot is empty or being drained.
  assign w_pop  = !w_empty && (!r_out_valid || out_ready);
  assign w_last = w_pop && !w_push && count == CW'(1);
  assign w_stall = r_out_valid && !out_ready && !w_empty;
  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (w_push),
    .i_data (w_cmd),
    .i_pop  (w_pop),
    .o_head (w_head),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_count(count)
  );
  // Chained commands read the accumulator, which is written on the same edge that issues its producer.
  assign sh_i   = w_empty ? '0 : (w_head.chain ? r_acc : w_head.data);
  assign sh_n   = w_empty ? '0 : w_head.n;
  assign sh_ar  = !w_empty && w_head.ar;
  assign sh_lr  = !w_empty && w_head.lr;
  assign sh_rot = !w_empty && w_head.rot;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = !w_empty || r_out_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_acc       <= '0;
      r_state     <= IDLE;
    end else begin
      if (w_pop) begin
        r_out_valid <= 1'b1;
        r_out_data  <= sh_o;
        r_acc       <= sh_o;
      end else if (out_ready) r_out_valid <= 1'b0;
      case (r_state)
        IDLE:    r_state <= w_empty ? IDLE : ISSUE;
        ISSUE:   r_state <= (w_empty || w_last) ? IDLE : (w_stall ? STALL : ISSUE);
        STALL:   r_state <= out_ready ? (w_empty ? IDLE : ISSUE) : STALL;
        default: r_state <= IDLE;
      endcase
    end
`ifdef SHIFT_CMD_SEQUENCER_STATS_EN
  logic [15:0] r_done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_done <= '0;
    else if (r_out_valid && out_ready) r_done <= r_done + 1'b1;
  assign done_cnt = r_done;
`endif
endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// tb_shift_cmd_sequencer: directed self-checking bench with a behavioural 8-bit shift unit attached
module tb_shift_cmd_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [7:0] in_data = '0;
  logic [3:0] in_n = '0;
  logic in_ar = 1'b0, in_lr = 1'b0, in_rot = 1'b0, in_chain = 1'b0;
  logic [7:0] sh_i, sh_o;
  logic [3:0] sh_n;
  logic sh_ar, sh_lr, sh_rot;
  logic out_valid, out_ready = 1'b1, busy;
  logic [7:0] out_data;
  logic [2:0] count;
`ifdef SHIFT_CMD_SEQUENCER_STATS_EN
  logic [15:0] done_cnt;
`endif
  int checks = 0, failures = 0;
  logic [15:0] w_l, w_r, w_a;
  always #5 clk = ~clk;
  always_comb begin
    w_l = {sh_i, sh_i} << sh_n;
    w_r = {sh_i, sh_i} >> sh_n;
    w_a = $signed({{8{sh_i[7]}}, sh_i}) >>> sh_n;
    sh_o = sh_lr ? (sh_rot ? w_l[15:8] : sh_i << sh_n)
                 : (sh_rot ? w_r[7:0] : (sh_ar ? w_a[7:0] : sh_i >> sh_n));
  end
  shift_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_n(in_n),
    .in_ar(in_ar), .in_lr(in_lr), .in_rot(in_rot), .in_chain(in_chain),
    .sh_i(sh_i), .sh_n(sh_n), .sh_ar(sh_ar), .sh_lr(sh_lr), .sh_rot(sh_rot), .sh_o(sh_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
`ifdef SHIFT_CMD_SEQUENCER_STATS_EN
    .done_cnt(done_cnt),
`endif
    .count(count)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [7:0] d, input logic [3:0] n, input logic ar, lr, rot, chain);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = d;
    in_n = n;
    in_ar = ar;
    in_lr = lr;
    in_rot = rot;
    in_chain = chain;
  endtask
  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  initial begin
    #1;
    check("rst_out_valid", 16'(out_valid), 16'h0);
    check("rst_count", 16'(count), 16'h0);
    check("rst_out_data", 16'(out_data), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_sh_i", 16'(sh_i), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("in_ready_after_rst", 16'(in_ready), 16'h1);
    drive(8'h81, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    check("ll_count", 16'(count), 16'h1);
    check("ll_wait_valid", 16'(out_valid), 16'h0);
    check("ll_sh_i", 16'(sh_i), 16'h81);
    check("ll_sh_n", 16'(sh_n), 16'h3);
    check("ll_sh_lr", 16'(sh_lr), 16'h1);
    @(negedge clk);
    check("ll_valid", 16'(out_valid), 16'h1);
    check("ll_data", 16'(out_data), 16'h08);
    check("ll_count0", 16'(count), 16'h0);
    @(negedge clk);
    check("ll_drain", 16'(out_valid), 16'h0);
    drive(8'h80, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("ar_data", 16'(out_data), 16'hE0);
    drive(8'h81, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(8'hFF, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    check("rotl_data", 16'(out_data), 16'h03);
    check("chain_sh_i", 16'(sh_i), 16'h03);
    @(negedge clk);
    check("chain_valid", 16'(out_valid), 16'h1);
    check("chain_data", 16'(out_data), 16'h0C);
    drive(8'h01, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(8'h5A, 4'd13, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    check("rotr_data", 16'(out_data), 16'h80);
    check("sat_sh_n", 16'(sh_n), 16'h8);
    check("sat_sh_i", 16'(sh_i), 16'h5A);
    @(negedge clk);
    check("sat_data", 16'(out_data), 16'h00);
    check("sat_valid", 16'(out_valid), 16'h1);
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) drive(8'(i), 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(8'h77, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("bp_count", 16'(count), 16'h4);
    check("bp_in_ready", 16'(in_ready), 16'h0);
    check("bp_data", 16'(out_data), 16'h02);
    check("bp_valid", 16'(out_valid), 16'h1);
    @(negedge clk);
    check("bp_blocked_count", 16'(count), 16'h4);
    check("bp_hold_data", 16'(out_data), 16'h02);
    out_ready = 1'b1;
    idle();
    check("full_pop_count", 16'(count), 16'h3);
    check("drain_1", 16'(out_data), 16'h04);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      check("drain_data", 16'(out_data), 16'(2 * (i + 1)));
      check("drain_count", 16'(count), 16'(4 - i));
    end
    @(negedge clk);
    check("drain_done_valid", 16'(out_valid), 16'h0);
    check("drain_done_busy", 16'(busy), 16'h0);
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) drive(8'(i << 4), 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    check("pre_rst_count", 16'(count), 16'h3);
    check("pre_rst_valid", 16'(out_valid), 16'h1);
    check("pre_rst_data", 16'(out_data), 16'h20);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 16'(out_valid), 16'h0);
    check("async_rst_count", 16'(count), 16'h0);
    check("async_rst_data", 16'(out_data), 16'h0);
`ifdef SHIFT_CMD_SEQUENCER_STATS_EN
    check("rst_done_cnt", done_cnt, 16'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(8'hFF, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    check("post_rst_chain_sh_i", 16'(sh_i), 16'h00);
    @(negedge clk);
    check("post_rst_valid", 16'(out_valid), 16'h1);
    check("post_rst_data", 16'(out_data), 16'h00);
`ifdef SHIFT_CMD_SEQUENCER_STATS_EN
    @(negedge clk);
    check("done_cnt", done_cnt, 16'h1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_cmd_sequencer.md
Name: shift_cmd_sequencer

Overview:
- Sequential front-end stage that feeds the 8-bit combinational shift unit (ar/lr/rot/n control) and consumes its result.
- Buffers shift commands in a small FIFO and issues at most one command per cycle to the shift unit.
- Registers each shift result into a valid/ready output stage.
- Keeps an accumulator so that a command can chain on the previous result instead of on fresh data.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, >=2).
- W, 8, data width; fixed to 8 to match the shift unit.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  command offered
- in_ready  out  1  FIFO can accept
- in_data  in  8  operand
- in_n  in  4  shift amount
- in_ar  in  1  arithmetic right
- in_lr  in  1  1 = left, 0 = right
- in_rot  in  1  rotate
- in_chain  in  1  use accumulator instead of in_data as operand
- sh_i  out  8  to shift unit operand
- sh_n  out  4  to shift unit amount
- sh_ar  out  1  to shift unit
- sh_lr  out  1  to shift unit
- sh_rot  out  1  to shift unit
- sh_o  in  8  shift unit result (combinational from sh_*)
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts
- out_data  out  8  registered result
- busy  out  1  FIFO non-empty or out_valid
- count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: FIFO empty, count=0, acc=0, out_valid=0, out_data=0, state=IDLE. in_ready=1 once reset is released.
- Push:
  - Occurs when in_valid && in_ready; in_ready = !full.
  - No same-cycle pass-through into a full FIFO.
  - in_n values 9..15 saturate to 8 at enqueue.
- FSM states:
  - IDLE: FIFO empty, out_valid=0. Go to ISSUE when count>0.
  - ISSUE: head valid and output slot free, i.e. !out_valid || out_ready.
    - Pop the head.
    - Capture sh_o into out_data; out_valid<=1; acc<=sh_o.
    - Stay in ISSUE if more entries remain.
    - Go to STALL if out_valid and !out_ready.
    - Go to IDLE when the FIFO becomes empty.
  - STALL: out_valid=1 and !out_ready. Hold out_data, acc and FIFO head stable. Return to ISSUE on out_ready.
- Output drain: out_valid drops when out_ready=1 and no pop occurs in that cycle.
- Shift-unit drive:
  - sh_* is driven combinationally from the FIFO head.
  - sh_i = head.chain ? acc : head.data.
  - When the FIFO is empty, sh_* = 0.
- Throughput and latency:
  - 1 command/cycle with out_ready held high.
  - Latency from push to out_valid: 2 cycles (enqueue edge, then issue edge).
- Chain hazard: the accumulator updates at the issue edge, so back-to-back chained commands see the prior result without bubbles.
- Simultaneous push and pop: count unchanged. When full, push is blocked even if a pop occurs.
- Count bounds: count never exceeds DEPTH and never underflows.
- Reset mid-operation: queued commands and any pending output are discarded. out_valid deasserts immediately (asynchronous).

Optional Feature:
- Macro: SHIFT_CMD_SEQUENCER_STATS_EN.
- Defined:
  - Adds output port done_cnt (16 bits). It increments on each out_valid && out_ready handshake and wraps at 0xFFFF->0.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package shift_pkg:
  - typedef shift_cmd_t {data[7:0], n[3:0], ar, lr, rot, chain}.
  - Constant SHIFT_MAX_N = 8.
  - FSM enum seq_state_t {IDLE, ISSUE, STALL}.
- Sub-module: cmd_fifo, a parameterised synchronous FIFO of shift_cmd_t with push/pop/full/empty/count.
- The shift unit stays external; it is connected through sh_*/sh_o.

Test Plan (with the real shift unit attached):
- Left logical, data 0x81, n=3, lr=1: out_data=0x08 two cycles after push.
- Arithmetic right, data 0x80, n=2, ar=1, lr=0: out_data=0xE0.
- Rotate left, 0x81, n=1: 0x03. Then a chained left logical with n=2 issued back-to-back: 0x0C, with no bubble.
- Rotate right, 0x01, n=1: 0x80. Then in_n=13 (saturated to 8) on 0x5A, logical right: 0x00.
- Backpressure:
  - Hold out_ready=0 and push 5 commands (DEPTH=4 plus one in the output slot).
  - in_ready=0 after the FIFO fills; out_data stable; count=4.
  - Release out_ready: results drain in order, one per cycle.
- Assert rst_n low mid-stream with count=3 and out_valid=1:
  - out_valid=0 and count=0 immediately.
  - After release, the first chained command uses acc=0.
  - With STATS_EN, done_cnt=0.
